// File: rtl/delta_tile_sequencer.sv
// Layer loop sequencer for the Delta accelerator: walks IC x OW x OH x OC tiles
// and drives one-cycle start pulses / done handshakes to the load, compute and store units.
module delta_tile_sequencer #(
  parameter int unsigned PU_NUM  = 4,
  parameter int unsigned PU_OC   = 8,
  parameter int unsigned TILE_IC = 8,
  parameter int unsigned TILE_OH = 8,
  parameter int unsigned TILE_OW = 8,
  parameter int unsigned CH_W    = 12,
  parameter int unsigned FS_W    = 9
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic                                      start,
  output logic                                      ack,
  output logic                                      done,
  output logic                                      busy,
  output logic                                      cfg_err,
  input  logic [CH_W-1:0]                           IC_Num,
  input  logic [CH_W-1:0]                           OC_Num,
  input  logic [FS_W-1:0]                           ORC_Size,
  input  logic                                      load_input,
  input  logic                                      store_output,
  output logic                                      isram_ld_start,
  input  logic                                      isram_ld_done,
  output logic                                      bias_ld_start,
  input  logic                                      bias_ld_done,
  output logic                                      ibuf_ld_start,
  input  logic                                      ibuf_ld_done,
  output logic                                      PU_start,
  output logic                                      weight_start,
  input  logic [PU_NUM-1:0]                         PU_finished,
  output logic                                      finish_cycle,
  output logic                                      obuf_st_start,
  input  logic                                      obuf_st_done,
  output logic                                      osram_st_start,
  input  logic                                      osram_st_done,
  output logic [1:0]                                dram_sel,
  output logic [CH_W-1:0]                           i_ch,
  output logic [CH_W-1:0]                           o_ch,
  output logic [FS_W-1:0]                           o_r,
  output logic [FS_W-1:0]                           o_c,
  output logic [$clog2(TILE_IC+1)-1:0]              PU_IC_Num,
  output logic [PU_NUM*$clog2(PU_OC+1)-1:0]         PU_OC_Num,
  output logic [PU_NUM-1:0]                         pu_active,
  output logic [$clog2(TILE_OH+1)-1:0]              tile_h,
  output logic [$clog2(TILE_OW+1)-1:0]              tile_w
);

  localparam int unsigned ICN_W   = $clog2(TILE_IC+1);
  localparam int unsigned OCN_W   = $clog2(PU_OC+1);
  localparam int unsigned TH_W    = $clog2(TILE_OH+1);
  localparam int unsigned TW_W    = $clog2(TILE_OW+1);
  localparam int unsigned OC_STEP = PU_NUM*PU_OC;

  typedef enum logic [3:0] {
    S_IDLE, S_ACK, S_CFG, S_ISRAM_LD, S_CHECK, S_BIAS_LD, S_IBUF_LD, S_OP_START,
    S_OP_WAIT, S_OP_FINISH, S_OBUF_ST, S_IDX_INC, S_OSRAM_ST, S_DONE
  } state_t;

  state_t          state, state_next;
  logic            first;
  logic [CH_W-1:0] ic_num, oc_num;
  logic [FS_W-1:0] orc_size;
  logic            load_in_q, store_out_q;

  logic [31:0] ic_sum, oc_sum, or_sum, och_sum;
  logic        ic_wrap, oc_wrap, or_wrap, och_wrap, cfg_zero, pu_all_done;

  // Candidate next index values and their wrap conditions
  assign ic_sum   = 32'(i_ch) + TILE_IC;
  assign oc_sum   = 32'(o_c) + TILE_OW;
  assign or_sum   = 32'(o_r) + TILE_OH;
  assign och_sum  = 32'(o_ch) + OC_STEP;
  assign ic_wrap  = ic_sum >= 32'(ic_num);
  assign oc_wrap  = oc_sum >= 32'(orc_size);
  assign or_wrap  = or_sum >= 32'(orc_size);
  assign och_wrap = och_sum >= 32'(oc_num);
  assign cfg_zero = (ic_num == '0) || (oc_num == '0) || (orc_size == '0);
  assign pu_all_done = &(PU_finished | ~pu_active);

  // State register; first marks the entry cycle of each state
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      first <= 1'b0;
    end else begin
      state <= state_next;
      first <= (state_next != state);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:      if (start) state_next = S_ACK;
      S_ACK:       state_next = S_CFG;
      S_CFG:       state_next = cfg_zero ? S_DONE : (load_in_q ? S_ISRAM_LD : S_CHECK);
      S_ISRAM_LD:  if (!first && isram_ld_done) state_next = S_CHECK;
      S_CHECK:     state_next = (i_ch == '0) ? S_BIAS_LD : S_IBUF_LD;
      S_BIAS_LD:   if (!first && bias_ld_done) state_next = S_IBUF_LD;
      S_IBUF_LD:   if (!first && ibuf_ld_done) state_next = S_OP_START;
      S_OP_START:  state_next = S_OP_WAIT;
      S_OP_WAIT:   if (pu_all_done) state_next = S_OP_FINISH;
      S_OP_FINISH: state_next = ic_wrap ? S_OBUF_ST : S_IDX_INC;
      S_OBUF_ST:   if (!first && obuf_st_done) state_next = S_IDX_INC;
      S_IDX_INC: begin
        if (ic_wrap && oc_wrap && or_wrap && och_wrap)
          state_next = store_out_q ? S_OSRAM_ST : S_DONE;
        else
          state_next = S_CHECK;
      end
      S_OSRAM_ST:  if (!first && osram_st_done) state_next = S_DONE;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ack            = 1'b0;
    done           = 1'b0;
    busy           = 1'b0;
    isram_ld_start = 1'b0;
    bias_ld_start  = 1'b0;
    ibuf_ld_start  = 1'b0;
    PU_start       = 1'b0;
    weight_start   = 1'b0;
    finish_cycle   = 1'b0;
    obuf_st_start  = 1'b0;
    osram_st_start = 1'b0;
    dram_sel       = 2'd0;
    busy           = (state != S_IDLE);
    unique case (state)
      S_ACK:       ack = 1'b1;
      S_DONE:      done = 1'b1;
      S_ISRAM_LD:  isram_ld_start = first;
      S_BIAS_LD: begin
        bias_ld_start = first;
        dram_sel      = 2'd2;
      end
      S_IBUF_LD:   ibuf_ld_start = first;
      S_OP_START: begin
        PU_start     = 1'b1;
        weight_start = 1'b1;
        dram_sel     = 2'd3;
      end
      S_OP_WAIT:   dram_sel = 2'd3;
      S_OP_FINISH: begin
        finish_cycle = 1'b1;
        dram_sel     = 2'd3;
      end
      S_OBUF_ST: begin
        obuf_st_start = first;
        dram_sel      = 2'd1;
      end
      S_OSRAM_ST: begin
        osram_st_start = first;
        dram_sel       = 2'd1;
      end
      default: ;
    endcase
  end

  // Config latch, error flag and tile index walk (IC innermost, OC outermost)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ic_num      <= '0;
      oc_num      <= '0;
      orc_size    <= '0;
      load_in_q   <= 1'b0;
      store_out_q <= 1'b0;
      cfg_err     <= 1'b0;
      i_ch        <= '0;
      o_ch        <= '0;
      o_r         <= '0;
      o_c         <= '0;
    end else begin
      if (state == S_ACK) begin
        ic_num      <= IC_Num;
        oc_num      <= OC_Num;
        orc_size    <= ORC_Size;
        load_in_q   <= load_input;
        store_out_q <= store_output;
        cfg_err     <= 1'b0;
        i_ch        <= '0;
        o_ch        <= '0;
        o_r         <= '0;
        o_c         <= '0;
      end
      if (state == S_CFG && cfg_zero) cfg_err <= 1'b1;
      if (state == S_IDX_INC) begin
        i_ch <= ic_wrap ? '0 : CH_W'(ic_sum);
        if (ic_wrap) o_c <= oc_wrap ? '0 : FS_W'(oc_sum);
        if (ic_wrap && oc_wrap) o_r <= or_wrap ? '0 : FS_W'(or_sum);
        if (ic_wrap && oc_wrap && or_wrap) o_ch <= och_wrap ? '0 : CH_W'(och_sum);
      end
    end
  end

  logic [31:0] ic_rem, h_rem, w_rem;

  // Per-tile valid counts; remainders clamp at zero instead of underflowing
  assign ic_rem    = (32'(ic_num) > 32'(i_ch)) ? 32'(ic_num) - 32'(i_ch) : '0;
  assign h_rem     = (32'(orc_size) > 32'(o_r)) ? 32'(orc_size) - 32'(o_r) : '0;
  assign w_rem     = (32'(orc_size) > 32'(o_c)) ? 32'(orc_size) - 32'(o_c) : '0;
  assign PU_IC_Num = ICN_W'((ic_rem > TILE_IC) ? TILE_IC : ic_rem);
  assign tile_h    = TH_W'((h_rem > TILE_OH) ? TILE_OH : h_rem);
  assign tile_w    = TW_W'((w_rem > TILE_OW) ? TILE_OW : w_rem);

  for (genvar k = 0; k < PU_NUM; k++) begin : g_lane
    logic [31:0] base, rem, lane;
    assign base = 32'(o_ch) + 32'(k) * PU_OC;
    assign rem  = (32'(oc_num) > base) ? 32'(oc_num) - base : '0;
    assign lane = (rem > PU_OC) ? PU_OC : rem;
    assign PU_OC_Num[k*OCN_W +: OCN_W] = OCN_W'(lane);
    assign pu_active[k] = (lane != '0);
  end

endmodule

// File: tb/tb_delta_tile_sequencer.sv
// Self-checking bench for delta_tile_sequencer: a nested-loop reference model fills
// an event scoreboard that a monitor pops as the DUT emits pulses.
module tb_delta_tile_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ack, done, busy, cfg_err;
  logic [11:0] IC_Num = '0, OC_Num = '0;
  logic [8:0]  ORC_Size = '0;
  logic        load_input = 1'b0, store_output = 1'b0;
  logic        isram_ld_start, bias_ld_start, ibuf_ld_start, obuf_st_start, osram_st_start;
  logic        PU_start, weight_start, finish_cycle;
  logic [4:0]  hs_done = '0;
  logic [3:0]  PU_finished = '0;
  logic [1:0]  dram_sel;
  logic [11:0] i_ch, o_ch;
  logic [8:0]  o_r, o_c;
  logic [3:0]  PU_IC_Num, pu_active, tile_h, tile_w;
  logic [15:0] PU_OC_Num;

  delta_tile_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .ack(ack), .done(done), .busy(busy),
    .cfg_err(cfg_err), .IC_Num(IC_Num), .OC_Num(OC_Num), .ORC_Size(ORC_Size),
    .load_input(load_input), .store_output(store_output),
    .isram_ld_start(isram_ld_start), .isram_ld_done(hs_done[0]),
    .bias_ld_start(bias_ld_start), .bias_ld_done(hs_done[1]),
    .ibuf_ld_start(ibuf_ld_start), .ibuf_ld_done(hs_done[2]),
    .PU_start(PU_start), .weight_start(weight_start), .PU_finished(PU_finished),
    .finish_cycle(finish_cycle),
    .obuf_st_start(obuf_st_start), .obuf_st_done(hs_done[3]),
    .osram_st_start(osram_st_start), .osram_st_done(hs_done[4]),
    .dram_sel(dram_sel), .i_ch(i_ch), .o_ch(o_ch), .o_r(o_r), .o_c(o_c),
    .PU_IC_Num(PU_IC_Num), .PU_OC_Num(PU_OC_Num), .pu_active(pu_active),
    .tile_h(tile_h), .tile_w(tile_w)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  kind;
    logic [1:0]  dsel;
    logic        ws;
    logic [3:0]  pic;
    logic [15:0] poc;
    logic [3:0]  act;
    logic [3:0]  th;
    logic [3:0]  tw;
    logic [11:0] ich;
    logic [11:0] och;
    logic [8:0]  orr;
    logic [8:0]  occ;
  } ev_t;

  ev_t sb[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0, ack_cyc = 0, done_cyc = 0, done_cnt = 0, p_cnt = 0;
  bit  early_done = 1'b0;
  logic [3:0] fin_mask = 4'hF;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk(input logic [7:0] kind);
    ev_t e = '0;
    e.kind = kind;
    case (kind)
      "B":         e.dsel = 2'd2;
      "P", "F":    e.dsel = 2'd3;
      "O", "S":    e.dsel = 2'd1;
      default:     e.dsel = 2'd0;
    endcase
    e.ws = (kind == "P");
    return e;
  endfunction

  function automatic int min8(input int v);
    return (v > 8) ? 8 : v;
  endfunction

  // Reference model: nested loops, IC innermost then cols, rows, OC groups of 32
  task automatic gen(input int ic, input int oc, input int orc, input bit li, input bit so);
    ev_t e;
    sb.push_back(mk("A"));
    if (ic == 0 || oc == 0 || orc == 0) begin
      sb.push_back(mk("D"));
      return;
    end
    if (li) sb.push_back(mk("I"));
    for (int och = 0; och < oc; och += 32)
      for (int r = 0; r < orc; r += 8)
        for (int c = 0; c < orc; c += 8)
          for (int i = 0; i < ic; i += 8) begin
            if (i == 0) sb.push_back(mk("B"));
            sb.push_back(mk("L"));
            e = mk("P");
            e.pic = 4'(min8(ic - i));
            for (int k = 0; k < 4; k++) begin
              int rem;
              rem = oc - och - 8*k;
              if (rem < 0) rem = 0;
              rem = min8(rem);
              e.poc[k*4 +: 4] = 4'(rem);
              e.act[k] = (rem > 0);
            end
            e.th  = 4'(min8(orc - r));
            e.tw  = 4'(min8(orc - c));
            e.ich = 12'(i);
            e.och = 12'(och);
            e.orr = 9'(r);
            e.occ = 9'(c);
            sb.push_back(e);
            sb.push_back(mk("F"));
            if (i + 8 >= ic) sb.push_back(mk("O"));
          end
    if (so) sb.push_back(mk("S"));
    sb.push_back(mk("D"));
  endtask

  // Handshake responders: done 2 cycles after start, optional bogus done in the start cycle
  logic [4:0] hs_start;
  assign hs_start = {osram_st_start, obuf_st_start, ibuf_ld_start, bias_ld_start, isram_ld_start};
  initial begin
    int cnt[5];
    int pcnt;
    for (int i = 0; i < 5; i++) cnt[i] = 0;
    pcnt = 0;
    forever begin
      @(posedge clock);
      #1;
      for (int i = 0; i < 5; i++) begin
        if (!reset) begin
          cnt[i] = 0;
          hs_done[i] = 1'b0;
        end else if (hs_start[i]) begin
          cnt[i] = 2;
          hs_done[i] = early_done;
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          hs_done[i] = (cnt[i] == 0);
        end else begin
          hs_done[i] = 1'b0;
        end
      end
      if (!reset) begin
        pcnt = 0;
        PU_finished = '0;
      end else if (PU_start) begin
        pcnt = 3;
      end else if (pcnt > 0) begin
        pcnt--;
        if (pcnt == 0) PU_finished = fin_mask;
      end
      if (finish_cycle) PU_finished = '0;
    end
  end

  // Monitor: every pulse pops one expected event
  initial begin
    ev_t o;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (reset) begin
        o = '0;
        if (ack)                 begin o.kind = "A"; ack_cyc = cyc; end
        else if (done)           begin o.kind = "D"; done_cyc = cyc; done_cnt++; end
        else if (isram_ld_start) o.kind = "I";
        else if (bias_ld_start)  o.kind = "B";
        else if (ibuf_ld_start)  o.kind = "L";
        else if (PU_start)       begin o.kind = "P"; p_cnt++; end
        else if (finish_cycle)   o.kind = "F";
        else if (obuf_st_start)  o.kind = "O";
        else if (osram_st_start) o.kind = "S";
        if (o.kind != 8'd0) begin
          o.dsel = dram_sel;
          o.ws   = weight_start;
          if (o.kind == "P") begin
            o.pic = PU_IC_Num;
            o.poc = PU_OC_Num;
            o.act = pu_active;
            o.th  = tile_h;
            o.tw  = tile_w;
            o.ich = i_ch;
            o.och = o_ch;
            o.orr = o_r;
            o.occ = o_c;
          end
          if (sb.size() == 0) chk("unexpected_event", 128'(o.kind), 128'(0));
          else chk("event", 128'(o), 128'(sb.pop_front()));
        end
      end
    end
  end

  function automatic logic [127:0] all_outs();
    return 128'({ack, done, busy, cfg_err, isram_ld_start, bias_ld_start, ibuf_ld_start,
                 PU_start, weight_start, finish_cycle, obuf_st_start, osram_st_start,
                 dram_sel, i_ch, o_ch, o_r, o_c, PU_IC_Num, PU_OC_Num, pu_active,
                 tile_h, tile_w});
  endfunction

  task automatic kick(input int ic, input int oc, input int orc, input bit li, input bit so);
    IC_Num = 12'(ic);
    OC_Num = 12'(oc);
    ORC_Size = 9'(orc);
    load_input = li;
    store_output = so;
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    IC_Num = 12'($urandom_range(0, 4095));
    OC_Num = 12'($urandom_range(0, 4095));
    ORC_Size = 9'($urandom_range(0, 511));
    load_input = ~li;
    store_output = ~so;
  endtask

  task automatic run_layer(input string tag, input int ic, input int oc, input int orc,
                           input bit li, input bit so, input bit early, input logic [3:0] mask);
    int d0;
    bit got;
    early_done = early;
    fin_mask = mask;
    gen(ic, oc, orc, li, so);
    d0 = done_cnt;
    kick(ic, oc, orc, li, so);
    got = 1'b0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(posedge clock); #2;
      got = (done_cnt != d0);
    end
    chk({tag, "_done_seen"}, 128'(got), 128'(1));
    chk({tag, "_sb_empty"}, 128'(sb.size()), 128'(0));
    sb.delete();
  endtask

  initial begin
    bit seen;
    #12;
    chk("reset_outputs", all_outs(), 128'(0));
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("idle_busy", 128'(busy), 128'(0));

    run_layer("ic16_oc32", 16, 32, 8, 1'b0, 1'b0, 1'b0, 4'hF);
    run_layer("ic12_oc20", 12, 20, 8, 1'b0, 1'b0, 1'b0, 4'h7);
    run_layer("orc12", 8, 8, 12, 1'b0, 1'b0, 1'b0, 4'h1);
    run_layer("oc40_ldst", 8, 40, 8, 1'b1, 1'b1, 1'b1, 4'hF);

    run_layer("zero_oc", 8, 0, 8, 1'b1, 1'b1, 1'b0, 4'hF);
    chk("cfg_err_set", 128'(cfg_err), 128'(1));
    chk("zero_done_latency", 128'(done_cyc - ack_cyc), 128'(2));
    run_layer("after_err", 8, 8, 8, 1'b0, 1'b0, 1'b0, 4'hF);
    chk("cfg_err_cleared", 128'(cfg_err), 128'(0));

    // Abort mid-OP_WAIT with an asynchronous reset
    early_done = 1'b0;
    fin_mask = 4'hF;
    gen(16, 32, 8, 1'b0, 1'b0);
    kick(16, 32, 8, 1'b0, 1'b0);
    seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(posedge clock); #1;
      seen = PU_start;
    end
    chk("abort_reached_op", 128'(seen), 128'(1));
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    chk("abort_outputs_zero", all_outs(), 128'(0));
    sb.delete();
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    chk("abort_idle", 128'(busy), 128'(0));
    run_layer("restart", 8, 16, 8, 1'b0, 1'b0, 1'b0, 4'h3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/delta_tile_sequencer.md
Name: delta_tile_sequencer

Overview:
- Parametrised top-level loop sequencer for the Delta accelerator. Walks a conv layer as IC x OW x OH x OC tiles and drives one-cycle start / done handshakes to the input, bias, weight, PU and output sub-units.
- Computes per-tile valid channel, row and column counts for any PU count, with ceiling-division remainders and no hard-coded PU lanes.
- Masks idle PUs. Stores the output buffer only after the last IC tile.

Parameters:
PU_NUM, 4, number of processing units
PU_OC, 8, output channels per PU per tile
TILE_IC, 8, input channels per tile
TILE_OH, 8, output rows per tile
TILE_OW, 8, output cols per tile
CH_W, 12, width of channel-count config and indices
FS_W, 9, width of feature-size config and indices

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-low reset
start  in  1  layer start request (level)
ack  out  1  one-cycle pulse: config latched
done  out  1  one-cycle pulse: layer complete
busy  out  1  high from ACK through DONE inclusive
cfg_err  out  1  sticky until next ack: zero-sized config
IC_Num  in  CH_W  input channels
OC_Num  in  CH_W  output channels
ORC_Size  in  FS_W  output rows = cols
load_input  in  1  run input-SRAM preload
store_output  in  1  run output-SRAM drain
isram_ld_start / isram_ld_done  out / in  1  input SRAM preload handshake
bias_ld_start / bias_ld_done  out / in  1  bias load handshake
ibuf_ld_start / ibuf_ld_done  out / in  1  input buffer load handshake
PU_start  out  1  operation start pulse
weight_start  out  1  weight manager start pulse (same cycle as PU_start)
PU_finished  in  PU_NUM  per-PU finished level
finish_cycle  out  1  one-cycle pulse after all active PUs finish
obuf_st_start / obuf_st_done  out / in  1  output buffer extract handshake
osram_st_start / osram_st_done  out / in  1  output SRAM drain handshake
dram_sel  out  2  0 input, 1 output, 2 bias, 3 weight
i_ch, o_ch  out  CH_W  current tile base channels
o_r, o_c  out  FS_W  current tile base row / col
PU_IC_Num  out  clog2(TILE_IC+1)  valid input channels this tile
PU_OC_Num  out  PU_NUM*clog2(PU_OC+1)  packed, lane k at [k*w +: w]
pu_active  out  PU_NUM  lane k has PU_OC_Num[k] > 0
tile_h, tile_w  out  clog2(TILE_OH+1), clog2(TILE_OW+1)  valid rows / cols this tile

Behaviour:
- Reset (reset == 0, asynchronous): state IDLE, indices 0, config registers 0, cfg_err 0.
- In reset, every output is 0 except pu_active, PU_*_Num and tile_* (combinational from the zeroed registers).
- An asserted reset aborts any in-flight handshake immediately.
- Control outputs are decoded from the state register only; there is no combinational path from any input to any output.
- States and transitions:
  - IDLE: on start, go to ACK.
  - ACK: pulse ack; latch IC_Num, OC_Num, ORC_Size, load_input, store_output; clear indices.
  - Zero-size config (any of IC_Num, OC_Num, ORC_Size equal 0): set cfg_err and go to DONE.
  - Otherwise go to ISRAM_LD if load_input, else CHECK.
- Handshake states (ISRAM_LD, BIAS_LD, IBUF_LD, OBUF_ST, OSRAM_ST):
  - The *_start pulse is asserted for exactly the first cycle in the state.
  - The matching *_done is sampled from the second cycle onward; a done seen in the first cycle is ignored.
  - Exit on the first sampled done.
- Transition order:
  - ISRAM_LD goes to CHECK.
  - CHECK goes to BIAS_LD when i_ch == 0, else to IBUF_LD.
  - BIAS_LD goes to IBUF_LD.
  - IBUF_LD goes to OP_START.
- OP_START: pulse PU_start and weight_start (1 cycle), then OP_WAIT.
- OP_WAIT: wait until (PU_finished | ~pu_active) is all ones, then OP_FINISH.
- OP_FINISH: pulse finish_cycle.
  - Last IC tile (i_ch + TILE_IC >= IC_Num): go to OBUF_ST.
  - Otherwise go to IDX_INC.
- OBUF_ST goes to IDX_INC.
- IDX_INC advances indices in this order: i_ch += TILE_IC; on wrap, o_c += TILE_OW; then o_r += TILE_OH; then o_ch += PU_NUM*PU_OC.
  - A dimension wraps when the new value is >= its limit (IC_Num, ORC_Size, OC_Num); the wrapped index returns to 0.
  - If o_ch wraps, go to OSRAM_ST when store_output, else DONE. Otherwise go to CHECK.
- DONE: pulse done, then IDLE. busy is low only in IDLE.
- dram_sel per state:
  - ISRAM_LD, IBUF_LD: 0.
  - OBUF_ST, OSRAM_ST: 1.
  - BIAS_LD: 2.
  - OP_START, OP_WAIT, OP_FINISH: 3.
  - All other states: 0.
- Count rules:
  - PU_IC_Num = min(TILE_IC, IC_Num - i_ch).
  - PU_OC_Num[k] = clamp(OC_Num - o_ch - k*PU_OC, 0, PU_OC), computed without underflow.
  - tile_h = min(TILE_OH, ORC_Size - o_r); tile_w likewise with o_c.
- start is ignored while busy. Config inputs may change after ack without effect.

Test Plan:
- IC=16, OC=32, ORC=8, defaults, all dones returned 2 cycles after start pulses -> 2 PU_start pulses; PU_IC_Num 8,8; 1 bias load; 1 obuf store, after the 2nd op only; pu_active=1111.
- IC=12, OC=20, ORC=8 -> PU_IC_Num 8 then 4; PU_OC_Num {8,8,4,0}; pu_active=0111; OP_WAIT exits with PU_finished=0111 while lane 3 is held 0.
- IC=8, OC=8, ORC=12 -> 4 spatial tiles, (o_r,o_c) = (0,0),(0,8),(8,0),(8,8); tile_h/tile_w 8/8, 8/4, 4/8, 4/4; 4 bias loads; 4 obuf stores.
- IC=8, OC=40 (2 OC tiles), load_input=1, store_output=1 -> isram_ld_start once before the first CHECK; osram_st_start once after o_ch wraps; then done; done arriving in the start cycle is ignored.
- OC_Num=0 -> ack, cfg_err=1, done 2 cycles after ack, no other starts; the next valid start clears cfg_err at ack.
- reset driven low mid-OP_WAIT -> all outputs 0 asynchronously; after release, state IDLE, start restarts from i_ch=o_ch=o_r=o_c=0.
